// File: rtl/bcd_digit_encoder_pkg.sv
// rtl/bcd_digit_encoder_pkg.sv - shared digit codes and state encoding for the BCD encoder
package bcd_digit_encoder_pkg;

    localparam int DIGIT_W = 5;
    localparam int BCD_W   = 12;

    localparam logic [DIGIT_W-1:0] CODE_BLANK = 5'd16;
    localparam logic [DIGIT_W-1:0] CODE_DASH  = 5'd17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // A BCD nibble is shown as its own value, zero-extended to a digit code.
    function automatic logic [DIGIT_W-1:0] nibble_code(input logic [3:0] nib);
        return {1'b0, nib};
    endfunction

endpackage

// File: rtl/bcd_digit_encoder_add3.sv
// rtl/bcd_digit_encoder_add3.sv - shift-and-add-3 correction for one BCD nibble
module bcd_add3_nibble (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // A nibble of 5 or more would exceed 9 after the next doubling, so pre-add 3.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_digit_encoder.sv
// rtl/bcd_digit_encoder.sv - sequential binary to three-digit display code converter
module bcd_digit_encoder
    import bcd_digit_encoder_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int MAX_VAL  = 999,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    value,
    output logic                busy,
    output logic                done,
    output logic [DIGIT_W-1:0]  u,
    output logic [DIGIT_W-1:0]  d,
    output logic [DIGIT_W-1:0]  c
);

    localparam int          CNT_W = $clog2(WIDTH + 1);
    localparam logic [31:0] MAX_U = 32'(MAX_VAL);

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     bin;
    logic [BCD_W-1:0]     bcd;
    logic [BCD_W-1:0]     bcd_adj;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf;
    logic [DIGIT_W-1:0]   code_u;
    logic [DIGIT_W-1:0]   code_d;
    logic [DIGIT_W-1:0]   code_c;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_add3
            bcd_add3_nibble u_add3 (
                .din  (bcd[4*g +: 4]),
                .dout (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one shift per cycle for WIDTH cycles, then a single FINISH cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Map the finished BCD accumulator to display codes (dashes on overflow, optional leading blanks).
    always_comb begin
        code_u = nibble_code(bcd[3:0]);
        code_d = nibble_code(bcd[7:4]);
        code_c = nibble_code(bcd[11:8]);
        if (ovf) begin
            code_u = CODE_DASH;
            code_d = CODE_DASH;
            code_c = CODE_DASH;
        end else if (BLANK_LZ) begin
            if (bcd[11:8] == 4'd0) begin
                code_c = CODE_BLANK;
                if (bcd[7:4] == 4'd0) begin
                    code_d = CODE_BLANK;
                end
            end
        end
    end

    // Datapath: capture on start, double-dabble while shifting, publish all digits together on FINISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            bcd  <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            u    <= CODE_BLANK;
            d    <= CODE_BLANK;
            c    <= CODE_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin  <= value;
                        bcd  <= '0;
                        cnt  <= CNT_W'(WIDTH);
                        ovf  <= (32'(value) > MAX_U);
                        busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt - CNT_W'(1);
                end
                FINISH: begin
                    u    <= code_u;
                    d    <= code_d;
                    c    <= code_c;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_digit_encoder.md
Name: bcd_digit_encoder

Overview:
Converts an unsigned binary count (0..999) into three 5-bit digit codes u, d, c: units, tens, hundreds. Codes 0-9 are digits, 16 is blank and 17 is dash. The block sits upstream of the 7-segment multiplexing driver and feeds its u/d/c inputs directly. Conversion is sequential (shift-and-add-3, one bit per clock) with a start/busy/done handshake. Outputs update atomically, so the display never shows a partial result.

Parameters:
WIDTH, 10, bit width of the binary input value.
MAX_VAL, 999, largest displayable value; anything above shows dash-dash-dash.
BLANK_LZ, 1, 1 = blank leading zeros of c and d; 0 = show all three digits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion of value; sampled only in IDLE
value  input  WIDTH  binary value to convert
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when u/d/c have just been updated
u  output  5  units digit code
d  output  5  tens digit code
c  output  5  hundreds digit code

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; u=d=c=16 (blank); internal shift and BCD registers cleared. Reset mid-conversion aborts it, and outputs go blank immediately.
- States:
  - IDLE -> SHIFT when start=1. On that edge (edge k): latch value into the shift register, clear the 12-bit BCD accumulator, set bit counter to WIDTH, set ovf flag = (value > MAX_VAL), busy=1.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1 and decrement the counter. After WIDTH shifts, go to FINISH.
  - FINISH: on exit edge, write u/d/c from BCD nibbles (or dashes), done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: start sampled at edge k -> outputs updated and done=1 after edge k+WIDTH+1 (11 cycles for WIDTH=10). Latency is constant, including the overflow case.
- Output mapping:
  - ovf=1 -> u=d=c=17.
  - Otherwise u=units nibble, d=tens nibble, c=hundreds nibble (zero-extended to 5 bits).
  - With BLANK_LZ=1: c=16 if hundreds==0; d=16 if hundreds==0 and tens==0; u is never blanked (0 displays "0").
- u/d/c are held unchanged from one FINISH to the next; they are never driven from intermediate SHIFT data.
- start while busy=1 (SHIFT or FINISH) is ignored and not queued. value may change freely after the capture edge.
- start held high continuously: a new conversion begins on the first IDLE cycle after each done, i.e. a period of WIDTH+2 cycles.
- All arithmetic is unsigned. BCD nibbles never exceed 9 after correction; value bits above MAX_VAL only set ovf.

Decomposition:
- Shared package holds: DIGIT_W=5, CODE_BLANK=5'd16, CODE_DASH=5'd17, the state encoding (IDLE, SHIFT, FINISH). The display driver uses the same code constants.
- One natural combinational sub-module, bcd_add3_nibble: 4-bit in, outputs in+3 when in>=5, else in. Instantiated once per BCD nibble (3x).

Test Plan:
- Reset, then start with value=305 -> busy for 11 cycles; done pulse; u=5, d=0, c=3; values hold until the next start.
- value=0, BLANK_LZ=1 -> u=0, d=16, c=16. value=40 -> u=0, d=4, c=16. value=7 with BLANK_LZ=0 -> u=7, d=0, c=0.
- value=999 -> 9,9,9. value=1000 and value=1023 -> u=d=c=17 after the same 11-cycle latency.
- Start 305, then pulse start with value=111 at cycles 3 and 11 (FINISH) -> result 305 only; a single done; busy never drops early.
- start held high with value=123 -> done pulses every 12 cycles; u=3, d=2, c=1 stable across conversions.
- Assert rst at cycle 5 of a conversion of 999 -> outputs immediately 16,16,16; busy=0; no done pulse; a subsequent start converts correctly.
